// File: rtl/axi_decerr_slave.sv
// Default AXI responder: completes every write and read burst with DECERR and
// records the first faulting address plus a saturating count of accepted requests.
module axi_decerr_slave #(
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = 64'hDEAD_BEEF_BADC_AB1E,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    input  logic                 err_clear_i
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    localparam int unsigned CntSumWidth = CntWidth + 1;

    w_state_e               w_state_q;
    r_state_e               r_state_q;
    logic [IdWidth-1:0]     b_id_q, r_id_q;
    logic [7:0]             r_len_q, r_cnt_q;
    logic                   err_valid_q, err_valid_d;
    logic [AddrWidth-1:0]   err_addr_q, err_addr_d;
    logic [CntWidth-1:0]    err_cnt_q, err_cnt_d;
    logic [CntWidth-1:0]    cnt_base;
    logic [CntSumWidth-1:0] cnt_sum;
    logic                   hs_aw, hs_ar;

    // Readies/valids are masked by reset so nothing handshakes while it is held.
    assign aw_ready_o = (w_state_q == W_IDLE) && !rst_i;
    assign w_ready_o  = (w_state_q == W_DATA) && !rst_i;
    assign b_valid_o  = (w_state_q == W_RESP) && !rst_i;
    assign ar_ready_o = (r_state_q == R_IDLE) && !rst_i;
    assign r_valid_o  = (r_state_q == R_DATA) && !rst_i;
    assign r_last_o   = r_valid_o && (r_cnt_q == r_len_q);

    assign b_id_o   = b_id_q;
    assign b_resp_o = 2'b11;
    assign r_id_o   = r_id_q;
    assign r_data_o = RespData;
    assign r_resp_o = 2'b11;

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_cnt_o   = err_cnt_q;

    assign hs_aw = aw_valid_i && aw_ready_o;
    assign hs_ar = ar_valid_i && ar_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (hs_aw) begin
                    b_id_q    <= aw_id_i;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_valid_i && w_last_i) w_state_q <= W_RESP;
                W_RESP: if (b_ready_i) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: if (hs_ar) begin
                    r_id_q    <= ar_id_i;
                    r_len_q   <= ar_len_i;
                    r_cnt_q   <= '0;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (r_ready_i) begin
                    if (r_cnt_q == r_len_q) r_state_q <= R_IDLE;
                    else                    r_cnt_q   <= r_cnt_q + 8'd1;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // A clear restarts from zero, but any handshake in the same cycle still lands.
    always_comb begin
        err_valid_d = err_valid_q && !err_clear_i;
        err_addr_d  = err_addr_q;
        if ((hs_aw || hs_ar) && (!err_valid_q || err_clear_i)) begin
            err_valid_d = 1'b1;
            err_addr_d  = hs_aw ? aw_addr_i : ar_addr_i;
        end
        cnt_base  = err_clear_i ? '0 : err_cnt_q;
        cnt_sum   = {1'b0, cnt_base} + CntSumWidth'(hs_aw) + CntSumWidth'(hs_ar);
        err_cnt_d = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed self-checking bench for axi_decerr_slave (instantiated with a 4-bit
// error counter so saturation is reachable quickly).
module tb_axi_decerr_slave;

    localparam int unsigned IdWidth   = 6;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned CntWidth  = 4;
    localparam logic [DataWidth-1:0] RespData = 64'hDEAD_BEEF_BADC_AB1E;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 aw_valid_i, aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [AddrWidth-1:0] aw_addr_i;
    logic                 w_valid_i, w_ready_o, w_last_i;
    logic                 b_valid_o, b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;
    logic                 ar_valid_i, ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [AddrWidth-1:0] ar_addr_i;
    logic [7:0]           ar_len_i;
    logic                 r_valid_o, r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 r_last_o;
    logic                 err_valid_o;
    logic [AddrWidth-1:0] err_addr_o;
    logic [CntWidth-1:0]  err_cnt_o;
    logic                 err_clear_i;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    axi_decerr_slave #(
        .IdWidth(IdWidth), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
        .RespData(RespData), .CntWidth(CntWidth)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o),
        .err_clear_i(err_clear_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_err();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0;
        w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i = 0; err_clear_i = 0;
        tick(); tick();
        compared++;
        if ({aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_handshake: got %b required 000000",
                     {aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o});
        end
        compared++;
        if (err_valid_o !== 1'b0 || err_addr_o !== '0 || err_cnt_o !== '0 || b_id_o !== '0 || r_id_o !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_err: valid=%b addr=%h cnt=%0d bid=%h rid=%h required all zero",
                     err_valid_o, err_addr_o, err_cnt_o, b_id_o, r_id_o);
        end
        rst_i = 1'b0;
        tick();
        compared++;
        if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_release: aw_ready=%b ar_ready=%b required 1 1", aw_ready_o, ar_ready_o);
        end
    endtask

    task automatic test_write();
        int beats;
        aw_valid_i = 1; aw_id_i = 6'h2A; aw_addr_i = 64'h6000_0000;
        w_valid_i = 1; w_last_i = 0;
        settle();
        compared++;
        if (w_ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_w_before_aw: w_ready=%b required 0", w_ready_o);
        end
        tick();
        aw_valid_i = 0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            w_last_i = (i == 3);
            settle();
            compared++;
            if (w_ready_o !== 1'b1 || b_valid_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL write_beat%0d: w_ready=%b b_valid=%b required 1 0", i, w_ready_o, b_valid_o);
            end
            tick();
            beats++;
        end
        w_valid_i = 0; w_last_i = 0;
        settle();
        compared++;
        if (b_valid_o !== 1'b1 || b_id_o !== 6'h2A || b_resp_o !== 2'b11 || w_ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_bresp: b_valid=%b b_id=%h b_resp=%b w_ready=%b required 1 2a 11 0",
                     b_valid_o, b_id_o, b_resp_o, w_ready_o);
        end
        compared++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 64'h6000_0000 || err_cnt_o !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL write_err: valid=%b addr=%h cnt=%0d required 1 60000000 1",
                     err_valid_o, err_addr_o, err_cnt_o);
        end
        b_ready_i = 1;
        tick();
        b_ready_i = 0;
        settle();
        compared++;
        if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL write_done: b_valid=%b aw_ready=%b required 0 1", b_valid_o, aw_ready_o);
        end
    endtask

    task automatic test_read();
        logic [4:0] pattern;
        int seen;
        pattern = 5'b11101;
        ar_valid_i = 1; ar_id_i = 6'h11; ar_addr_i = 64'h7000_0000; ar_len_i = 8'd3;
        r_ready_i = 0;
        tick();
        ar_valid_i = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            r_ready_i = pattern[i];
            settle();
            compared++;
            if (r_valid_o !== 1'b1 || r_id_o !== 6'h11 || r_data_o !== RespData ||
                r_resp_o !== 2'b11 || r_last_o !== (seen == 3)) begin
                mismatched++;
                $display("[TB] FAIL read_cycle%0d: valid=%b id=%h data=%h resp=%b last=%b required 1 11 %h 11 %b",
                         i, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, RespData, (seen == 3));
            end
            if (r_valid_o && r_ready_i) seen++;
            tick();
        end
        r_ready_i = 0;
        settle();
        compared++;
        if (seen != 4 || r_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL read_done: beats=%0d r_valid=%b ar_ready=%b required 4 0 1", seen, r_valid_o, ar_ready_o);
        end
    endtask

    task automatic test_concurrent();
        aw_valid_i = 1; aw_id_i = 6'h01; aw_addr_i = 64'hA;
        ar_valid_i = 1; ar_id_i = 6'h02; ar_addr_i = 64'hB; ar_len_i = 8'd0;
        tick();
        aw_valid_i = 0; ar_valid_i = 0;
        compared++;
        if (err_addr_o !== 64'hA || err_cnt_o !== 4'd2 || err_valid_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL concurrent_capture: addr=%h cnt=%0d valid=%b required a 2 1", err_addr_o, err_cnt_o, err_valid_o);
        end
        r_ready_i = 1; w_valid_i = 1; w_last_i = 1;
        tick();
        r_ready_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
        tick();
        b_ready_i = 0;
        ar_valid_i = 1; ar_addr_i = 64'hC;
        tick();
        ar_valid_i = 0;
        compared++;
        if (err_addr_o !== 64'hA || err_cnt_o !== 4'd3) begin
            mismatched++;
            $display("[TB] FAIL concurrent_hold: addr=%h cnt=%0d required a 3", err_addr_o, err_cnt_o);
        end
        r_ready_i = 1;
        tick();
        r_ready_i = 0;
    endtask

    task automatic test_saturation_clear();
        clear_err();
        r_ready_i = 1; ar_len_i = 8'd0; ar_addr_i = 64'h100;
        for (int i = 0; i < 17; i++) begin
            ar_valid_i = 1;
            tick();
            ar_valid_i = 0;
            tick();
        end
        r_ready_i = 0;
        compared++;
        if (err_cnt_o !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL saturate: cnt=%0d required 15", err_cnt_o);
        end
        err_clear_i = 1; aw_valid_i = 1; aw_addr_i = 64'hD;
        tick();
        err_clear_i = 0; aw_valid_i = 0;
        compared++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 64'hD || err_cnt_o !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL clear_with_aw: valid=%b addr=%h cnt=%0d required 1 d 1", err_valid_o, err_addr_o, err_cnt_o);
        end
        w_valid_i = 1; w_last_i = 1;
        tick();
        w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
        tick();
        b_ready_i = 0;
        clear_err();
        compared++;
        if (err_valid_o !== 1'b0 || err_cnt_o !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL clear_alone: valid=%b cnt=%0d required 0 0", err_valid_o, err_cnt_o);
        end
    endtask

    task automatic test_max_read();
        int seen;
        int lastErr;
        ar_valid_i = 1; ar_id_i = 6'h3F; ar_addr_i = 64'h200; ar_len_i = 8'd255;
        tick();
        ar_valid_i = 0;
        r_ready_i = 1;
        seen = 0;
        lastErr = 0;
        for (int c = 0; c < 300 && r_valid_o; c++) begin
            if (r_last_o !== (seen == 255)) lastErr++;
            seen++;
            tick();
        end
        r_ready_i = 0;
        compared++;
        if (seen != 256 || lastErr != 0) begin
            mismatched++;
            $display("[TB] FAIL max_read_beats: beats=%0d bad_last=%0d required 256 0", seen, lastErr);
        end
        compared++;
        if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL max_read_done: ar_ready=%b r_valid=%b required 1 0", ar_ready_o, r_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ar_valid_i = 1; ar_id_i = 6'h05; ar_addr_i = 64'h300; ar_len_i = 8'd7;
        tick();
        ar_valid_i = 0;
        r_ready_i = 1;
        tick();
        rst_i = 1;
        tick();
        compared++;
        if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_abort: r_valid=%b ar_ready=%b required 0 0", r_valid_o, ar_ready_o);
        end
        rst_i = 0; r_ready_i = 0;
        tick();
        compared++;
        if (ar_ready_o !== 1'b1 || err_cnt_o !== 4'd0 || r_valid_o !== 1'b0 || err_valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_release: ar_ready=%b cnt=%0d r_valid=%b err_valid=%b required 1 0 0 0",
                     ar_ready_o, err_cnt_o, r_valid_o, err_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        clear_err();
        test_read();
        compared++;
        if (err_cnt_o !== 4'd1 || err_addr_o !== 64'h7000_0000) begin
            mismatched++;
            $display("[TB] FAIL read_err: cnt=%0d addr=%h required 1 70000000", err_cnt_o, err_addr_o);
        end
        clear_err();
        test_concurrent();
        test_saturation_clear();
        test_max_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- Default responder on the SoC AXI crossbar, attached to the no-rule-match port.
- Completes every burst addressed outside the peripheral map (Debug..DRAM) with DECERR, so CVA6, debug and the IOMMU masters never hang on a stray address.
- Also latches the first offending address and counts faulty transactions, for debug and IOMMU fault diagnosis.

Parameters:
- IdWidth, 6, AXI ID width; matches the slave-side ID width of the crossbar (4 + log2(4 masters)).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, R data width.
- RespData, 64'hDEAD_BEEF_BADC_AB1E, constant returned on every R beat.
- CntWidth, 16, width of the error counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write address
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  response ID
- b_resp_o  out  2  response code, always 2'b11 (DECERR)
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  burst length minus 1
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  read ID
- r_data_o  out  DataWidth  read data, always RespData
- r_resp_o  out  2  read response, always 2'b11
- r_last_o  out  1  last read beat
- err_valid_o  out  1  err_addr_o holds a captured address
- err_addr_o  out  AddrWidth  first faulting address since last clear
- err_cnt_o  out  CntWidth  saturating count of accepted AW+AR
- err_clear_i  in  1  clears err_valid_o and err_cnt_o

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous, active-high.
- Reset: both FSMs go to IDLE. All valid/ready outputs are 0 while rst_i=1. err_valid_o=0, err_addr_o=0, err_cnt_o=0, ids=0, r_last_o=0.
- Write and read FSMs are fully independent; concurrent operation is allowed.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: aw_ready_o=1. On AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Discard beats. On a handshake with w_last_i=1, go to W_RESP. aw_len is ignored; termination is by w_last only.
  - W_RESP: b_valid_o=1, b_id_o=latched ID. On b_ready_i, go to W_IDLE.
  - Latency: w_ready_o from the cycle after AW; b_valid_o the cycle after the last W handshake.
  - W beats presented before AW acceptance are not accepted (w_ready_o=0 in W_IDLE).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ID and len, set beat counter=0, go to R_DATA.
  - R_DATA: r_valid_o=1. r_last_o = (counter==len). Counter increments on each r handshake. The handshake with r_last_o=1 returns to R_IDLE.
  - Beats = len+1, range 1..256; the 8-bit counter does not wrap before last.
  - First beat is valid the cycle after AR. r_valid_o holds and all R outputs are stable while r_ready_i=0.
- Error capture:
  - On AW or AR handshake with err_valid_o=0: latch the address and set err_valid_o.
  - Same-cycle AW and AR: the AW address wins.
  - Once set, the captured address is held until cleared.
- Error counter:
  - err_cnt_o += number of handshakes this cycle (0, 1 or 2).
  - Saturates at all-ones; no wrap.
- Clear:
  - err_clear_i alone: err_valid_o=0, err_cnt_o=0 next cycle.
  - err_clear_i with a same-cycle handshake: the new event wins, i.e. err_valid_o=1 with the new address, and err_cnt_o = handshakes this cycle.
- Reset mid-burst: outstanding bursts are abandoned with no further B/R beats; both FSMs return to IDLE.

Test Plan:
- Write path: AW id=0x2A addr=0x6000_0000, then W beats (w_last on the 4th) → w_ready_o high only after AW; b_valid_o the cycle after the 4th beat with b_id_o=0x2A, b_resp_o=2'b11; err_addr_o=0x6000_0000, err_cnt_o=1.
- Read path: AR id=0x11 len=3 with r_ready_i toggling 1,0,1,1,1 → exactly 4 beats, r_data_o=RespData, r_resp_o=2'b11, r_last_o only on the 4th, outputs stable during the stall.
- Concurrent capture: AW addr 0xA and AR addr 0xB in the same cycle → err_addr_o=0xA, err_cnt_o=2; a later AR to 0xC leaves err_addr_o=0xA, err_cnt_o=3.
- Counter saturation and clear: with CntWidth=4, issue 17 ARs with len=0 → err_cnt_o holds 15. Assert err_clear_i in the same cycle as an AW to 0xD → err_valid_o=1, err_addr_o=0xD, err_cnt_o=1.
- Max-length read: AR len=255 → exactly 256 beats, r_last_o only on beat 256, then ar_ready_o=1 again.
- Reset mid-operation: assert rst_i during beat 2 of a len=7 read → r_valid_o=0 from the next cycle; after release ar_ready_o=1 and err_cnt_o=0.
